glitch_sequencer: RTL



---
 rtl/glitch_sequencer_pkg.sv | 21 ++
 rtl/glitch_sequencer_if.sv | 38 +++
 rtl/glitch_sequencer_timer.sv | 39 +++
 rtl/glitch_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/glitch_sequencer_pkg.sv
// glitch_pkg: shared types and default sizing for the glitch sequencer.
//   state_e         - sequencer FSM states
//   GS_CNT_W        - default width of the offset/duration/gap/hold counters
//   GS_MAX_PULSES   - default maximum pulses per trigger
//   GS_HOLD_CYCLES  - default TX hold-off after the last pulse
package glitch_pkg;

    localparam int GS_CNT_W       = 32;
    localparam int GS_MAX_PULSES  = 4;
    localparam int GS_HOLD_CYCLES = 100000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_OFFSET,
        ST_PULSE,
        ST_GAP,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/glitch_sequencer_if.sv
// glitch_sequencer_if: control, configuration and status bundle of the
// glitch sequencer.
//   master modport - drives arm/abort/trigger/config, observes status
//   slave modport  - the sequencer side
//   arm, abort, trigger_in, trig_rise, cfg_offset, cfg_duration, cfg_gap,
//   cfg_count (requests/config) ; glitch_out, busy, done, tx_release (status)
interface glitch_sequencer_if import glitch_pkg::*; #(
    parameter int CNT_W      = GS_CNT_W,
    parameter int MAX_PULSES = GS_MAX_PULSES
);
    localparam int CNT_PW = $clog2(MAX_PULSES + 1);

    logic              arm;
    logic              abort;
    logic              trigger_in;
    logic              trig_rise;
    logic [CNT_W-1:0]  cfg_offset;
    logic [CNT_W-1:0]  cfg_duration;
    logic [CNT_W-1:0]  cfg_gap;
    logic [CNT_PW-1:0] cfg_count;
    logic              glitch_out;
    logic              busy;
    logic              done;
    logic              tx_release;

    modport master (
        output arm, abort, trigger_in, trig_rise,
               cfg_offset, cfg_duration, cfg_gap, cfg_count,
        input  glitch_out, busy, done, tx_release
    );

    modport slave (
        input  arm, abort, trigger_in, trig_rise,
               cfg_offset, cfg_duration, cfg_gap, cfg_count,
        output glitch_out, busy, done, tx_release
    );

endinterface

// File: rtl/glitch_sequencer_timer.sv
// glitch_timer: loadable down-counter with zero flags.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (has priority over dec)
//   dec       - decrement; ignored at zero so the counter never wraps
//   zero      - current count is zero
//   nxt_zero  - count after this edge will be zero (lets the owner register
//               outputs that coincide with the zero cycle)
module glitch_timer import glitch_pkg::*; #(
    parameter int CNT_W = GS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             nxt_zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign zero     = (cnt_q == '0);
    assign nxt_zero = (cnt_d == '0);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: arms on request, waits for a selected trigger edge, then
// emits cfg_count glitch pulses (offset/duration/gap timed) and withholds the
// target TX until a quiet hold-off period has elapsed.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - glitch_sequencer_if.slave (config in, glitch/status out)
// All outputs are registered and derived from the next state.
module glitch_sequencer import glitch_pkg::*; #(
    parameter int CNT_W       = GS_CNT_W,
    parameter int MAX_PULSES  = GS_MAX_PULSES,
    parameter int HOLD_CYCLES = GS_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    glitch_sequencer_if.slave  bus
);

    localparam int               CW      = $clog2(MAX_PULSES + 1);
    localparam logic [CW-1:0]    MAX_P   = CW'(MAX_PULSES);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] off_q, off_d, dur_q, dur_d, gap_q, gap_d;
    logic [CW-1:0]    pulses_q, pulses_d;
    logic             rise_q, rise_d, trig_q, trig_d;
    logic             glitch_q, glitch_d, busy_q, busy_d;
    logic             done_q, done_d, tx_q, tx_d;

    logic             tmr_load, tmr_dec, tmr_zero, tmr_nxt_zero;
    logic [CNT_W-1:0] tmr_val, dur_m1, gap_m1;
    logic             edge_seen, trig_active;

    glitch_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero),
        .nxt_zero (tmr_nxt_zero)
    );

    always_comb begin
        // Phases last max(x,1) cycles; the timer runs x-1 .. 0.
        dur_m1      = (dur_q == '0) ? '0 : dur_q - CNT_W'(1);
        gap_m1      = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
        edge_seen   = rise_q ? (bus.trigger_in & ~trig_q) : (~bus.trigger_in & trig_q);
        trig_active = rise_q ? bus.trigger_in : ~bus.trigger_in;

        state_d  = state_q;
        off_d    = off_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        pulses_d = pulses_q;
        rise_d   = rise_q;
        trig_d   = bus.trigger_in;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.arm && bus.cfg_count != '0) begin
                    off_d    = bus.cfg_offset;
                    dur_d    = bus.cfg_duration;
                    gap_d    = bus.cfg_gap;
                    pulses_d = (bus.cfg_count > MAX_P) ? MAX_P : bus.cfg_count;
                    rise_d   = bus.trig_rise;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Zero offset skips OFFSET so the pulse starts the next cycle.
                if (edge_seen) begin
                    tmr_load = 1'b1;
                    if (off_q == '0) begin
                        tmr_val = dur_m1;
                        state_d = ST_PULSE;
                    end else begin
                        tmr_val = off_q - CNT_W'(1);
                        state_d = ST_OFFSET;
                    end
                end
            end
            ST_OFFSET, ST_GAP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = dur_m1;
                    state_d  = ST_PULSE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (pulses_q <= CW'(1)) begin
                        tmr_val = HOLD_LD;
                        state_d = ST_HOLD;
                    end else begin
                        tmr_val  = gap_m1;
                        pulses_d = pulses_q - CW'(1);
                        state_d  = ST_GAP;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                // Zero wins over a trigger reload, so the done pulse that was
                // registered on the way to zero is always followed by IDLE.
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else if (trig_active) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.abort) begin
            state_d  = ST_IDLE;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end

        glitch_d = (state_d == ST_PULSE);
        busy_d   = (state_d != ST_IDLE);
        tx_d     = (state_d == ST_IDLE);
        // done marks the HOLD cycle whose count is zero (the last busy cycle).
        done_d   = (state_d == ST_HOLD) && tmr_nxt_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            off_q    <= '0;
            dur_q    <= '0;
            gap_q    <= '0;
            pulses_q <= '0;
            rise_q   <= 1'b0;
            trig_q   <= 1'b0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            dur_q    <= dur_d;
            gap_q    <= gap_d;
            pulses_q <= pulses_d;
            rise_q   <= rise_d;
            trig_q   <= trig_d;
            glitch_q <= glitch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tx_q     <= tx_d;
        end
    end

    assign bus.glitch_out = glitch_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.tx_release = tx_q;

endmodule
